// File: rtl/tug_field.sv
// Tug-of-war playfield: rope position, round win detection, saturating scores and LED decode.
// Optional FALSE_START_EN: a single press while the display is dark gives the round to the opponent.
module tug_field #(
  parameter int NPOS    = 7,
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pbl,
  input  logic               pbr,
  input  logic               leds_on,
  input  logic [1:0]         led_ctrl,
  input  logic               clr,
  output logic               winrnd,
  output logic [NPOS-1:0]    leds,
  output logic [SCORE_W-1:0] scorel,
  output logic [SCORE_W-1:0] scorer
);

  localparam int            PW   = $clog2(NPOS);
  localparam logic [PW-1:0] CTR  = PW'((NPOS - 1) / 2);
  localparam logic [PW-1:0] LAST = PW'(NPOS - 1);

  logic [PW-1:0] pos;
  logic [PW-1:0] pos_nxt;
  logic          round_over;
  logic          ro_nxt;
  logic          clr_d;
  logic          win_l;
  logic          win_r;
  logic          start;
  logic          play;
  logic          one_press;
`ifdef FALSE_START_EN
  logic          dark;
`endif

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  always_comb begin
    pos_nxt   = pos;
    ro_nxt    = round_over;
    win_l     = 1'b0;
    win_r     = 1'b0;
    one_press = pbl ^ pbr;
    start     = clr_d & ~clr;
    play      = ~clr & leds_on & (led_ctrl == 2'b10) & ~round_over;
`ifdef FALSE_START_EN
    dark      = ~clr & (led_ctrl == 2'b00) & ~round_over;
`endif
    // A round start wins over any press in the same cycle.
    if (start) begin
      pos_nxt = CTR;
      ro_nxt  = 1'b0;
    end else if (play && one_press) begin
      pos_nxt = pbr ? pos + PW'(1) : pos - PW'(1);
      win_l   = (pos_nxt == '0);
      win_r   = (pos_nxt == LAST);
    end
`ifdef FALSE_START_EN
    else if (dark && one_press) begin
      pos_nxt = pbl ? LAST : '0;
      win_r   = pbl;
      win_l   = pbr;
    end
`endif
    if (win_l || win_r) ro_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos        <= CTR;
      round_over <= 1'b0;
      clr_d      <= 1'b1;
      winrnd     <= 1'b0;
      scorel     <= '0;
      scorer     <= '0;
    end else begin
      pos        <= pos_nxt;
      round_over <= ro_nxt;
      clr_d      <= clr;
      winrnd     <= win_l | win_r;
      if (win_l) scorel <= sat_inc(scorel);
      if (win_r) scorer <= sat_inc(scorer);
    end
  end

  always_comb begin
    leds = '0;
    if (leds_on) begin
      case (led_ctrl)
        2'b11:   leds = '1;
        2'b10:   leds = NPOS'(1) << pos;
        default: leds = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tug_field.sv
// Randomized and directed bench for tug_field against a per-cycle behavioural game model.
module tb_tug_field;

  localparam int NPOS    = 7;
  localparam int SCORE_W = 4;
  localparam int CTR     = (NPOS - 1) / 2;
  localparam int SMAX    = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               pbl = 1'b0;
  logic               pbr = 1'b0;
  logic               leds_on = 1'b0;
  logic [1:0]         led_ctrl = 2'b00;
  logic               clr = 1'b1;
  logic               winrnd;
  logic [NPOS-1:0]    leds;
  logic [SCORE_W-1:0] scorel;
  logic [SCORE_W-1:0] scorer;

  int checks = 0;
  int errors = 0;

  // Game model state
  int m_pos = CTR;
  bit m_over = 0;
  bit m_clrd = 1;
  int m_sl = 0;
  int m_sr = 0;
  bit m_win = 0;

  tug_field #(.NPOS(NPOS), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .leds_on(leds_on),
    .led_ctrl(led_ctrl), .clr(clr), .winrnd(winrnd), .leds(leds),
    .scorel(scorel), .scorer(scorer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NPOS-1:0] exp_leds();
    logic [NPOS-1:0] e;
    e = '0;
    if (leds_on) begin
      if (led_ctrl == 2'b11) e = '1;
      else if (led_ctrl == 2'b10) e[m_pos] = 1'b1;
    end
    return e;
  endfunction

  task automatic award(input bit left);
    m_over = 1;
    m_win  = 1;
    if (left) m_sl = (m_sl < SMAX) ? m_sl + 1 : SMAX;
    else      m_sr = (m_sr < SMAX) ? m_sr + 1 : SMAX;
  endtask

  // Game rules applied at one clock edge using the inputs held across it.
  task automatic model_edge();
    bit single;
    single = (pbl != pbr);
    m_win = 0;
    if (rst) begin
      m_pos = CTR; m_over = 0; m_clrd = 1; m_sl = 0; m_sr = 0;
    end else begin
      if (m_clrd && !clr) begin
        m_pos = CTR; m_over = 0;
      end else if (!clr && !m_over && single) begin
        if (leds_on && led_ctrl == 2'b10) begin
          m_pos = pbr ? m_pos + 1 : m_pos - 1;
          if (m_pos == 0) award(1);
          else if (m_pos == NPOS - 1) award(0);
        end
`ifdef FALSE_START_EN
        else if (led_ctrl == 2'b00) begin
          m_pos = pbl ? NPOS - 1 : 0;
          award(pbr);
        end
`endif
      end
      m_clrd = clr;
    end
  endtask

  task automatic step(input logic r, input logic l, input logic rr, input logic on,
                      input logic [1:0] lc, input logic c);
    rst = r; pbl = l; pbr = rr; leds_on = on; led_ctrl = lc; clr = c;
    #1;
    if (!r) check("leds", 32'(leds), 32'(exp_leds()));
    @(posedge clk);
    model_edge();
    #1;
    check("winrnd", 32'(winrnd), 32'(m_win));
    check("scorel", 32'(scorel), 32'(m_sl));
    check("scorer", 32'(scorer), 32'(m_sr));
  endtask

  task automatic play(input logic l, input logic r);
    step(1'b0, l, r, 1'b1, 2'b10, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
  endtask

  task automatic new_round();
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
    idle();
  endtask

  initial begin
    logic c_r;
    logic on_r;
    logic [1:0] lc_r;
    int sel;

    // Reset and first round start
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("rst_winrnd", 32'(winrnd), 32'd0);
    check("rst_scorel", 32'(scorel), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    idle();
    check("centre", 32'(leds), 32'(7'b0001000));

    // Left player pulls to a win
    play(1, 0); idle(); play(1, 0); idle(); play(1, 0);
    check("lwin_pulse", 32'(winrnd), 32'd1);
    idle();
    check("lwin_once", 32'(winrnd), 32'd0);
    check("lwin_score", 32'(scorel), 32'd1);
    play(0, 1);
    idle();
    check("lwin_hold", 32'(leds), 32'(7'b0000001));

    // Simultaneous presses cancel, clr freezes
    new_round();
    play(1, 1);
    idle();
    check("cancel", 32'(leds), 32'(7'b0001000));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
    check("frozen", 32'(leds), 32'(7'b0001000));

    // Press in the dark window
    idle();
    step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    idle();

    // Right score saturation
    for (int w = 0; w < 16; w++) begin
      new_round();
      play(0, 1); idle(); play(0, 1); idle(); play(0, 1);
      check("sat_pulse", 32'(winrnd), 32'd1);
    end
    check("sat_score", 32'(scorer), 32'(SMAX));

    // Reset beats a winning press
    new_round();
    play(0, 1); play(0, 1);
    check("at5", 32'(leds), 32'(7'b0100000));
    step(1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
    check("rst_nowin", 32'(winrnd), 32'd0);
    check("rst_scorer", 32'(scorer), 32'd0);
    idle();
    check("rst_centre", 32'(leds), 32'(7'b0001000));

    // Randomized play
    c_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (c_r) c_r = ($urandom_range(0, 3) != 0);
      else     c_r = ($urandom_range(0, 39) == 0);
      on_r = ($urandom_range(0, 15) != 0);
      sel  = $urandom_range(0, 9);
      lc_r = (sel < 6) ? 2'b10 : (sel == 6) ? 2'b11 : (sel == 7) ? 2'b00 : 2'b01;
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), on_r, lc_r, c_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
